// File: rtl/up_axi_master_if.sv
// AXI4-Lite bus bundle between up_axi_master and an AXI4-Lite slave.
interface up_axi_master_if #(
   parameter int AXI_ADDR_WIDTH = 16,
   parameter int AXI_DATA_WIDTH = 32
);
   logic [AXI_ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]                  awprot;
   logic                        awvalid;
   logic                        awready;
   logic [AXI_DATA_WIDTH-1:0]   wdata;
   logic [AXI_DATA_WIDTH/8-1:0] wstrb;
   logic                        wvalid;
   logic                        wready;
   logic [1:0]                  bresp;
   logic                        bvalid;
   logic                        bready;
   logic [AXI_ADDR_WIDTH-1:0]   araddr;
   logic [2:0]                  arprot;
   logic                        arvalid;
   logic                        arready;
   logic [AXI_DATA_WIDTH-1:0]   rdata;
   logic [1:0]                  rresp;
   logic                        rvalid;
   logic                        rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/up_axi_master.sv
// AXI4-Lite master: converts up-bus write/read requests into single
// outstanding AXI4-Lite transactions, acknowledging each with a one-cycle pulse.
module up_axi_master #(
   parameter int AXI_ADDR_WIDTH = 16,
   parameter int AXI_DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      up_wreq,
   input  logic [AXI_ADDR_WIDTH-3:0] up_waddr,
   input  logic [31:0]               up_wdata,
   output logic                      up_wack,
   output logic                      up_werr,
   input  logic                      up_rreq,
   input  logic [AXI_ADDR_WIDTH-3:0] up_raddr,
   output logic [31:0]               up_rdata,
   output logic                      up_rack,
   output logic                      up_rerr,
   up_axi_master_if.master           m_axi
);

   if (AXI_DATA_WIDTH != 32) begin : g_width_check
      $error("up_axi_master supports only AXI_DATA_WIDTH = 32");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WR_RESP,
      S_RD_ADDR,
      S_RD_DATA,
      S_ACK
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic                      aw_done;
   logic                      w_done;
   logic                      aw_hs;
   logic                      w_hs;
   logic                      is_wr;
   logic                      err;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
   logic [AXI_ADDR_WIDTH-1:0] araddr_q;
   logic [31:0]               wdata_q;
   logic [31:0]               rdata_q;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      aw_hs         = 1'b0;
      w_hs          = 1'b0;
      m_axi.awvalid = 1'b0;
      m_axi.wvalid  = 1'b0;
      m_axi.bready  = 1'b0;
      m_axi.arvalid = 1'b0;
      m_axi.rready  = 1'b0;
      up_wack       = 1'b0;
      up_rack       = 1'b0;
      up_werr       = 1'b0;
      up_rerr       = 1'b0;
      case (state)
         S_IDLE: begin
            if (up_wreq)      state_nxt = S_WR;
            else if (up_rreq) state_nxt = S_RD_ADDR;
         end
         S_WR: begin
            // AW and W retire independently; leave once both have handshaken
            m_axi.awvalid = !aw_done;
            m_axi.wvalid  = !w_done;
            aw_hs         = !aw_done && m_axi.awready;
            w_hs          = !w_done && m_axi.wready;
            if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_WR_RESP;
         end
         S_WR_RESP: begin
            m_axi.bready = 1'b1;
            if (m_axi.bvalid) state_nxt = S_ACK;
         end
         S_RD_ADDR: begin
            m_axi.arvalid = 1'b1;
            if (m_axi.arready) state_nxt = S_RD_DATA;
         end
         S_RD_DATA: begin
            m_axi.rready = 1'b1;
            if (m_axi.rvalid) state_nxt = S_ACK;
         end
         S_ACK: begin
            up_wack   = is_wr;
            up_rack   = !is_wr;
            up_werr   = is_wr && err;
            up_rerr   = !is_wr && err;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         is_wr    <= 1'b0;
         err      <= 1'b0;
         awaddr_q <= '0;
         araddr_q <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               aw_done <= 1'b0;
               w_done  <= 1'b0;
               if (up_wreq) begin
                  awaddr_q <= {up_waddr, 2'b00};
                  wdata_q  <= up_wdata;
                  is_wr    <= 1'b1;
               end else if (up_rreq) begin
                  araddr_q <= {up_raddr, 2'b00};
                  is_wr    <= 1'b0;
               end
            end
            S_WR: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
            end
            S_WR_RESP: begin
               if (m_axi.bvalid) err <= (m_axi.bresp != 2'b00);
            end
            S_RD_DATA: begin
               if (m_axi.rvalid) begin
                  rdata_q <= m_axi.rdata;
                  err     <= (m_axi.rresp != 2'b00);
               end
            end
            default: ;
         endcase
      end
   end

   assign m_axi.awaddr = awaddr_q;
   assign m_axi.awprot = '0;
   assign m_axi.wdata  = wdata_q;
   assign m_axi.wstrb  = '1;
   assign m_axi.araddr = araddr_q;
   assign m_axi.arprot = '0;
   assign up_rdata     = rdata_q;

endmodule

// File: tb/tb_up_axi_master.sv
// Bench for up_axi_master: delay-programmable AXI4-Lite slave, write scoreboard,
// valid-hold protocol checks, vector table, corner sequences and random traffic.
module tb_up_axi_master;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          up_wreq = 1'b0;
   logic [AW-3:0] up_waddr = '0;
   logic [31:0]   up_wdata = '0;
   logic          up_wack;
   logic          up_werr;
   logic          up_rreq = 1'b0;
   logic [AW-3:0] up_raddr = '0;
   logic [31:0]   up_rdata;
   logic          up_rack;
   logic          up_rerr;

   always #5 clk = ~clk;

   up_axi_master_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(32)) axi ();

   up_axi_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata),
      .up_wack(up_wack), .up_werr(up_werr),
      .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata),
      .up_rack(up_rack), .up_rerr(up_rerr),
      .m_axi(axi.master)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // slave configuration, set by the requester before each transaction
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

   typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
   wr_t exp_wq[$];
   logic [31:0] slv_mem [int unsigned];
   logic [31:0] ref_mem [int unsigned];

   function automatic logic [31:0] dflt(input logic [15:0] byte_addr);
      return {16'hA5A5, byte_addr};
   endfunction

   function automatic logic [31:0] model_rd(input logic [13:0] word);
      if (ref_mem.exists(int'(word))) return ref_mem[int'(word)];
      return dflt({word, 2'b00});
   endfunction

   // slave: sample handshakes at posedge, drive responses at negedge
   initial begin : slave
      bit have_aw = 0, have_w = 0, b_busy = 0, r_busy = 0, rst_q = 1;
      bit aw_pend = 0, w_pend = 0, ar_pend = 0;
      logic [15:0] pa_aw = '0, pa_ar = '0, s_awaddr = '0, s_araddr = '0;
      logic [31:0] pd_w = '0, s_wdata = '0;
      int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
      wr_t e;
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
      axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
      forever begin
         @(posedge clk);
         rst_q = rst;
         if (rst) begin
            have_aw = 0; have_w = 0; b_busy = 0; r_busy = 0;
            aw_pend = 0; w_pend = 0; ar_pend = 0;
         end else begin
            if (aw_pend) check("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, pa_aw});
            if (w_pend)  check("w_hold", {axi.wvalid, axi.wdata}, {1'b1, pd_w});
            if (ar_pend) check("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, pa_ar});
            if (axi.arvalid || axi.rready)
               check("rd_wr_overlap", axi.awvalid | axi.wvalid | axi.bready, 0);
            check("err_outside_ack", {up_werr & ~up_wack, up_rerr & ~up_rack}, 0);
            if (axi.awvalid && axi.awready) begin
               have_aw = 1; s_awaddr = axi.awaddr;
               check("awprot", axi.awprot, 0);
            end
            if (axi.wvalid && axi.wready) begin
               have_w = 1; s_wdata = axi.wdata;
               check("wstrb", axi.wstrb, 4'hF);
            end
            if (axi.bvalid && axi.bready) b_busy = 0;
            if (axi.arvalid && axi.arready) begin
               r_busy = 1; s_araddr = axi.araddr;
               check("arprot", axi.arprot, 0);
            end
            if (axi.rvalid && axi.rready) r_busy = 0;
            if (have_aw && have_w) begin
               if (exp_wq.size() == 0) check("unexpected_write", 1, 0);
               else begin
                  e = exp_wq.pop_front();
                  check("wr_addr", s_awaddr, e.a);
                  check("wr_data", s_wdata, e.d);
               end
               slv_mem[int'(s_awaddr)] = s_wdata;
               have_aw = 0; have_w = 0; b_busy = 1;
            end
            aw_pend = axi.awvalid && !axi.awready; pa_aw = axi.awaddr;
            w_pend  = axi.wvalid && !axi.wready;   pd_w  = axi.wdata;
            ar_pend = axi.arvalid && !axi.arready; pa_ar = axi.araddr;
         end
         @(negedge clk);
         if (rst_q) begin
            axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0; axi.rvalid = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
         end else begin
            if (axi.awvalid && !have_aw) begin
               if (aw_cnt >= aw_dly) axi.awready = 1; else begin axi.awready = 0; aw_cnt++; end
            end else begin axi.awready = 0; aw_cnt = 0; end
            if (axi.wvalid && !have_w) begin
               if (w_cnt >= w_dly) axi.wready = 1; else begin axi.wready = 0; w_cnt++; end
            end else begin axi.wready = 0; w_cnt = 0; end
            if (b_busy) begin
               if (b_cnt >= b_dly) begin axi.bvalid = 1; axi.bresp = bresp_cfg; end
               else begin axi.bvalid = 0; b_cnt++; end
            end else begin axi.bvalid = 0; b_cnt = 0; end
            if (axi.arvalid && !r_busy) begin
               if (ar_cnt >= ar_dly) axi.arready = 1; else begin axi.arready = 0; ar_cnt++; end
            end else begin axi.arready = 0; ar_cnt = 0; end
            if (r_busy) begin
               if (r_cnt >= r_dly) begin
                  axi.rvalid = 1; axi.rresp = rresp_cfg;
                  axi.rdata = slv_mem.exists(int'(s_araddr)) ? slv_mem[int'(s_araddr)] : dflt(s_araddr);
               end else begin axi.rvalid = 0; r_cnt++; end
            end else begin axi.rvalid = 0; r_cnt = 0; end
         end
      end
   end

   // one transaction, started and finished at a negedge
   task automatic do_txn(input string tag, input bit wr, input logic [13:0] addr,
                         input logic [31:0] data, input int a, input int d, input int r,
                         input logic [1:0] resp, input int exp_lat, input logic exp_err);
      int n = 0, acnt = 0, dcnt = 0;
      bit got = 0;
      logic err_s = 0;
      if (wr) begin
         aw_dly = a; w_dly = d; b_dly = r; bresp_cfg = resp;
         exp_wq.push_back('{{addr, 2'b00}, data});
         ref_mem[int'(addr)] = data;
         up_waddr = addr; up_wdata = data; up_wreq = 1;
      end else begin
         ar_dly = a; r_dly = r; rresp_cfg = resp;
         up_raddr = addr; up_rreq = 1;
      end
      while (!got && n < 300) begin
         @(negedge clk);
         n++;
         if (wr) begin
            if (axi.awvalid) acnt++;
            if (axi.wvalid) dcnt++;
            if (up_wack) begin got = 1; err_s = up_werr; check({tag, "_no_rack"}, up_rack, 0); end
         end else begin
            if (axi.arvalid) acnt++;
            if (up_rack) begin got = 1; err_s = up_rerr; check({tag, "_no_wack"}, up_wack, 0); end
         end
      end
      up_wreq = 0; up_rreq = 0;
      check({tag, "_ack_seen"}, got, 1);
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_err"}, err_s, exp_err);
      if (wr) begin
         check({tag, "_aw_cycles"}, acnt, a + 1);
         check({tag, "_w_cycles"}, dcnt, d + 1);
      end else begin
         check({tag, "_ar_cycles"}, acnt, a + 1);
         check({tag, "_rdata"}, up_rdata, data);
      end
      @(negedge clk);
      check({tag, "_ack_pulse_end"}, {up_wack, up_rack}, 0);
      if (!wr) check({tag, "_rdata_hold"}, up_rdata, data);
   endtask

   typedef struct {
      bit wr; logic [13:0] addr; logic [31:0] data;
      int a; int d; int r; logic [1:0] resp; int lat; logic err;
   } vec_t;

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t vecs[8];
      int n, t_ack;
      bit got;
      vecs[0] = '{1'b1, 14'h0004, 32'hDEADBEEF, 0, 0, 0, 2'b00, 3, 1'b0};
      vecs[1] = '{1'b1, 14'h0010, 32'hCAFEF00D, 0, 3, 0, 2'b00, 6, 1'b0};
      vecs[2] = '{1'b1, 14'h0001, 32'h12345678, 2, 0, 1, 2'b10, 6, 1'b1};
      vecs[3] = '{1'b0, 14'h0001, 32'h12345678, 0, 0, 5, 2'b10, 8, 1'b1};
      vecs[4] = '{1'b0, 14'h0004, 32'hDEADBEEF, 2, 0, 1, 2'b00, 6, 1'b0};
      vecs[5] = '{1'b1, 14'h3FFF, 32'hFFFFFFFF, 0, 0, 0, 2'b11, 3, 1'b1};
      vecs[6] = '{1'b0, 14'h3FFF, 32'hFFFFFFFF, 0, 0, 0, 2'b00, 3, 1'b0};
      vecs[7] = '{1'b0, 14'h0000, 32'hA5A50000, 1, 0, 2, 2'b01, 6, 1'b1};

      repeat (3) @(negedge clk);
      check("reset_outputs",
            {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
             up_wack, up_rack, up_werr, up_rerr}, 0);
      check("reset_rdata", up_rdata, 0);
      rst = 0;
      @(negedge clk);

      foreach (vecs[i])
         do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
                vecs[i].a, vecs[i].d, vecs[i].r, vecs[i].resp, vecs[i].lat, vecs[i].err);

      // simultaneous write and read: write first, AR two cycles after the write ack
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; bresp_cfg = 0; rresp_cfg = 0;
      exp_wq.push_back('{16'h0404, 32'h600DCAFE});
      ref_mem[int'(14'h0101)] = 32'h600DCAFE;
      up_waddr = 14'h0101; up_wdata = 32'h600DCAFE; up_raddr = 14'h0101;
      up_wreq = 1; up_rreq = 1;
      n = 0; t_ack = 0; got = 0;
      while (!got && n < 100) begin
         @(negedge clk); n++;
         if (up_wack) begin
            got = 1; t_ack = n;
            check("both_write_first", up_rack, 0);
            up_wreq = 0;
         end
      end
      check("both_wack_seen", got, 1);
      got = 0;
      while (!got && n < 200) begin
         @(negedge clk); n++;
         if (axi.arvalid) got = 1;
      end
      check("both_ar_delay", n - t_ack, 2);
      got = 0;
      while (!got && n < 300) begin
         @(negedge clk); n++;
         if (up_rack) begin got = 1; check("both_rdata", up_rdata, model_rd(14'h0101)); end
      end
      check("both_rack_seen", got, 1);
      up_rreq = 0;
      @(negedge clk);

      // reset while waiting for the write response
      aw_dly = 0; w_dly = 0; b_dly = 20; bresp_cfg = 0;
      exp_wq.push_back('{16'h0408, 32'h0BADF00D});
      ref_mem[int'(14'h0102)] = 32'h0BADF00D;
      up_waddr = 14'h0102; up_wdata = 32'h0BADF00D; up_wreq = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!axi.bready && n < 20);
      check("abort_in_wr_resp", axi.bready, 1);
      rst = 1; up_wreq = 0;
      @(negedge clk);
      check("abort_outputs",
            {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
             up_wack, up_rack, up_werr, up_rerr}, 0);
      check("abort_rdata", up_rdata, 0);
      rst = 0;
      @(negedge clk);
      check("abort_no_ack", {up_wack, up_rack}, 0);
      do_txn("after_abort", 1'b0, 14'h0102, model_rd(14'h0102), 0, 0, 0, 2'b00, 3, 1'b0);

      // randomized back-to-back traffic against the reference model
      for (int unsigned k = 0; k < 100; k++) begin
         bit          wr;
         logic [13:0] addr;
         logic [31:0] data;
         int          a, d, r, lat;
         logic [1:0]  resp;
         wr   = 1'($urandom_range(0, 1));
         addr = 14'($urandom_range(0, 15));
         a    = int'($urandom_range(0, 3));
         d    = int'($urandom_range(0, 3));
         r    = int'($urandom_range(0, 3));
         resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if (wr) begin
            data = $urandom;
            lat  = 3 + ((a > d) ? a : d) + r;
         end else begin
            data = model_rd(addr);
            lat  = 3 + a + r;
         end
         do_txn($sformatf("rnd%0d", k), wr, addr, data, a, d, r, resp, lat, resp != 2'b00);
      end

      check("scoreboard_drained", exp_wq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/up_axi_master.md
Name: up_axi_master

Overview:
- AXI4-Lite master that turns the team's simple register request bus (up_wreq/up_rreq) into AXI4-Lite transactions.
- It is the initiator counterpart of up_axi, the AXI4-Lite slave to up-bus bridge.
- Used by on-chip controllers (e.g. a time-sync sequencer) to program and read axi_rtc and other AXI4-Lite peripherals without a processor.
- One outstanding transaction at a time.

Parameters:
- AXI_ADDR_WIDTH, 16: AXI byte-address width. The up-bus word address is AXI_ADDR_WIDTH-2 bits.
- AXI_DATA_WIDTH, 32: AXI data width. Only 32 is supported; any other value triggers an elaboration error.

Ports:
- clk  in  1  clock; all ports are synchronous to it
- rst  in  1  synchronous active-high reset
- up_wreq  in  1  write request level; held high until up_wack
- up_waddr  in  AXI_ADDR_WIDTH-2  write word address
- up_wdata  in  32  write data
- up_wack  out  1  one-cycle write-done pulse
- up_werr  out  1  valid with up_wack; 1 when BRESP != OKAY
- up_rreq  in  1  read request level; held high until up_rack
- up_raddr  in  AXI_ADDR_WIDTH-2  read word address
- up_rdata  out  32  read data; valid from up_rack until the next read completes
- up_rack  out  1  one-cycle read-done pulse
- up_rerr  out  1  valid with up_rack; 1 when RRESP != OKAY
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  AXI_ADDR_WIDTH/3/1/1  AXI write address channel
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  AXI write data channel
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  AXI write response channel
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  AXI_ADDR_WIDTH/3/1/1  AXI read address channel
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  AXI read data channel

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; all m_axi valids/readies=0; up_wack=up_rack=up_werr=up_rerr=0; up_rdata=0.
- Reset mid-transaction aborts immediately to IDLE with valids dropped. The slave shares this reset.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, ACK.
- IDLE:
  - up_wreq=1 → WR. Latch awaddr={up_waddr,2'b00} and wdata.
  - Else up_rreq=1 → RD_ADDR. Latch araddr={up_raddr,2'b00}.
  - Write has priority when both are high. The read is served after the write's ACK.
- WR:
  - awvalid and wvalid both rise on entry.
  - Each drops independently on its own handshake (valid&ready); the two may complete in either order or in the same cycle.
  - When both handshakes are done → WR_RESP.
- WR_RESP: bready=1. On bvalid → ACK. Capture werr=(bresp!=2'b00).
- RD_ADDR: arvalid=1. On arready → RD_DATA.
- RD_DATA: rready=1. On rvalid → ACK. Capture up_rdata=m_axi_rdata (also on error). Capture rerr=(rresp!=2'b00).
- ACK:
  - Pulse up_wack (or up_rack) with its err bit for exactly one cycle → IDLE.
  - The requester drops req at the edge ending ACK, so IDLE never re-issues the same request.
- Fixed outputs: awprot=arprot=3'b000, wstrb=4'hF.
- Outputs are stable while valid=1 and ready=0; no valid drops before its handshake.
- Minimum latency, req high at edge N with a zero-wait slave:
  - write: AW/W handshake cycle N+1, B cycle N+2, up_wack cycle N+3;
  - read: AR cycle N+1, R cycle N+2, up_rack cycle N+3.
- Back-to-back transactions: the next transaction is issued no earlier than one cycle after ACK (the IDLE cycle).
- Requests dropped before ack are a protocol violation. The latched address/data are used regardless.
- up_werr/up_rerr are 0 outside ack cycles.

Test Plan:
- Zero-wait slave, up_wreq addr 0x0004, data 0xDEADBEEF → awaddr=0x0010, wdata=0xDEADBEEF, wstrb=F, awvalid/wvalid high cycle N+1 only, up_wack=1 at N+3, up_werr=0.
- Slave returns awready 3 cycles before wready → awvalid drops after its handshake, wvalid held with stable data until wready; single up_wack after bvalid.
- up_rreq addr 0x0001, slave rvalid after 5 waits with rdata 0x12345678, rresp=2'b10 → up_rack one cycle, up_rdata=0x12345678 held afterwards, up_rerr=1.
- up_wreq and up_rreq rise same cycle → write completes (up_wack) first, then read issues two cycles later, up_rack follows; no overlap of AW and AR.
- rst asserted while in WR_RESP → next cycle all valids/readies 0, no ack; after release a new read completes normally.
- 100 randomized back-to-back writes/reads against a slave with random ready/valid delays → scoreboard matches every address/data; a protocol checker flags no valid drops or payload changes before handshake.
